// File: rtl/cu_sequencer_if.sv
// Control/handshake bundle between a compute-unit sequencer and its scheduler, fetch, LSU and RF neighbours.
interface cu_sequencer_if #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned PC_WIDTH  = 8
);
  logic                 start;
  logic [PC_WIDTH-1:0]  base_pc;
  logic [NUM_LANES-1:0] active_lanes;
  logic                 fetch_req;
  logic [PC_WIDTH-1:0]  fetch_addr;
  logic                 fetch_valid;
  logic                 is_read;
  logic                 is_write;
  logic                 is_ret;
  logic                 branch_taken;
  logic [PC_WIDTH-1:0]  branch_target;
  logic [NUM_LANES-1:0] lsu_done;
  logic                 lsu_req;
  logic [3:0]           cu_state;
  logic                 rf_enable;
  logic                 rf_ren;
  logic                 rf_wen;
  logic [PC_WIDTH-1:0]  pc;
  logic                 busy;
  logic                 done;

  modport master (
    input  start, base_pc, active_lanes, fetch_valid, is_read, is_write, is_ret,
           branch_taken, branch_target, lsu_done,
    output fetch_req, fetch_addr, lsu_req, cu_state, rf_enable, rf_ren, rf_wen,
           pc, busy, done
  );

  modport slave (
    output start, base_pc, active_lanes, fetch_valid, is_read, is_write, is_ret,
           branch_taken, branch_target, lsu_done,
    input  fetch_req, fetch_addr, lsu_req, cu_state, rf_enable, rf_ren, rf_wen,
           pc, busy, done
  );
endinterface

// File: rtl/cu_sequencer.sv
// Per-compute-unit control FSM: owns the PC, sequences fetch/decode/LSU/execute/writeback
// and broadcasts its state to every lane register file.
module cu_sequencer #(
  parameter int unsigned NUM_LANES  = 4,
  parameter int unsigned PC_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH = 16
) (
  input logic            clk,
  input logic            reset,
  cu_sequencer_if.master bus
);

  if (DATA_WIDTH == 0) begin : g_bad_data_width
    $error("cu_sequencer: DATA_WIDTH must be non-zero");
  end

  // Encoding is shared with the lane register files and must not change.
  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_REQ       = 4'd3,
    S_WAIT      = 4'd4,
    S_EXECUTE   = 4'd5,
    S_WRITEBACK = 4'd6,
    S_DONE      = 4'd7
  } state_t;

  state_t               state, state_nx;
  logic [PC_WIDTH-1:0]  pc_q, pc_nx;
  logic [NUM_LANES-1:0] lane_mask, lane_mask_nx;
  logic [NUM_LANES-1:0] done_mask, done_mask_nx;
  logic                 mem_op, mem_op_nx;
  logic                 first_wait;
  logic                 lanes_done;

  // A completion arriving this cycle counts immediately; inactive lanes count as finished.
  assign lanes_done = &(done_mask | bus.lsu_done | ~lane_mask);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      pc_q       <= '0;
      lane_mask  <= '0;
      done_mask  <= '0;
      mem_op     <= 1'b0;
      first_wait <= 1'b0;
    end else begin
      state      <= state_nx;
      pc_q       <= pc_nx;
      lane_mask  <= lane_mask_nx;
      done_mask  <= done_mask_nx;
      mem_op     <= mem_op_nx;
      first_wait <= (state == S_REQ);
    end
  end

  always_comb begin
    state_nx     = state;
    pc_nx        = pc_q;
    lane_mask_nx = lane_mask;
    done_mask_nx = done_mask;
    mem_op_nx    = mem_op;
    case (state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          pc_nx        = bus.base_pc;
          lane_mask_nx = bus.active_lanes;
          state_nx     = (bus.active_lanes == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (bus.fetch_valid) state_nx = S_DECODE;
      end
      S_DECODE: begin
        // Latched so lsu_req depends only on registered state.
        mem_op_nx = bus.is_read | bus.is_write;
        state_nx  = S_REQ;
      end
      S_REQ: begin
        done_mask_nx = '0;
        state_nx     = S_WAIT;
      end
      S_WAIT: begin
        if (mem_op) begin
          done_mask_nx = done_mask | (bus.lsu_done & lane_mask);
          if (lanes_done) state_nx = S_EXECUTE;
        end else begin
          state_nx = S_EXECUTE;
        end
      end
      S_EXECUTE: state_nx = S_WRITEBACK;
      S_WRITEBACK: begin
        if (bus.is_ret) begin
          state_nx = S_DONE;
        end else if (bus.branch_taken) begin
          pc_nx    = bus.branch_target;
          state_nx = S_FETCH;
        end else begin
          pc_nx    = pc_q + 1'b1;
          state_nx = S_FETCH;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign bus.cu_state   = state;
  assign bus.pc         = pc_q;
  assign bus.fetch_addr = pc_q;
  assign bus.fetch_req  = (state == S_FETCH);
  assign bus.lsu_req    = (state == S_WAIT) && mem_op && first_wait;
  assign bus.rf_ren     = (state == S_REQ);
  assign bus.rf_wen     = (state == S_WRITEBACK);
  assign bus.rf_enable  = (state != S_IDLE) && (state != S_DONE);
  assign bus.busy       = (state != S_IDLE) && (state != S_DONE);
  assign bus.done       = (state == S_DONE);

endmodule
